// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the Icache/Dcache memory-port arbiter.
//   XLEN / DATA_W / TAG_W / NUM_TAGS : bus and tag geometry
//   BUS_*                            : memory bus command encodings
//   owner_e / tag_entry_t            : owner-table entry layout
//   DEF_STARVE_LIMIT                 : default Icache starvation bound
package mem_arb_pkg;

    localparam int unsigned XLEN             = 32;
    localparam int unsigned DATA_W           = 64;
    localparam int unsigned TAG_W            = 4;
    localparam int unsigned NUM_TAGS         = 1 << TAG_W;
    localparam int unsigned DEF_STARVE_LIMIT = 8;

    typedef logic [1:0] bus_cmd_t;
    localparam bus_cmd_t BUS_NONE  = 2'd0;
    localparam bus_cmd_t BUS_LOAD  = 2'd1;
    localparam bus_cmd_t BUS_STORE = 2'd2;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e who;
    } tag_entry_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two caches, the memory model and the arbiter.
//   slave  : arbiter view (takes cache/memory inputs, drives proc2mem/ctrl2* outputs)
//   master : environment view (caches + memory)
// MEM_ARBITER_PERF_EN adds the grant/starvation performance counters.
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic [1:0]        Icache2ctrl_command;
    logic [XLEN-1:0]   Icache2ctrl_addr;
    logic [1:0]        Dcache2ctrl_command;
    logic [XLEN-1:0]   Dcache2ctrl_addr;
    logic [DATA_W-1:0] Dcache2ctrl_data;
    logic [TAG_W-1:0]  mem2proc_response;
    logic [DATA_W-1:0] mem2proc_data;
    logic [TAG_W-1:0]  mem2proc_tag;

    logic [1:0]        proc2mem_command;
    logic [XLEN-1:0]   proc2mem_addr;
    logic [DATA_W-1:0] proc2mem_data;
    logic [TAG_W-1:0]  ctrl2Icache_response;
    logic [DATA_W-1:0] ctrl2Icache_data;
    logic [TAG_W-1:0]  ctrl2Icache_tag;
    logic [TAG_W-1:0]  ctrl2Dcache_response;
    logic [DATA_W-1:0] ctrl2Dcache_data;
    logic [TAG_W-1:0]  ctrl2Dcache_tag;
    logic              d_grant;
    logic              tag_err;
`ifdef MEM_ARBITER_PERF_EN
    logic [31:0]       i_grant_cnt;
    logic [31:0]       d_grant_cnt;
    logic [31:0]       starve_force_cnt;
`endif

    modport slave (
        input  Icache2ctrl_command, Icache2ctrl_addr,
        input  Dcache2ctrl_command, Dcache2ctrl_addr, Dcache2ctrl_data,
        input  mem2proc_response, mem2proc_data, mem2proc_tag,
        output proc2mem_command, proc2mem_addr, proc2mem_data,
        output ctrl2Icache_response, ctrl2Icache_data, ctrl2Icache_tag,
        output ctrl2Dcache_response, ctrl2Dcache_data, ctrl2Dcache_tag,
        output d_grant, tag_err
`ifdef MEM_ARBITER_PERF_EN
        , output i_grant_cnt, d_grant_cnt, starve_force_cnt
`endif
    );

    modport master (
        output Icache2ctrl_command, Icache2ctrl_addr,
        output Dcache2ctrl_command, Dcache2ctrl_addr, Dcache2ctrl_data,
        output mem2proc_response, mem2proc_data, mem2proc_tag,
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
        input  ctrl2Icache_response, ctrl2Icache_data, ctrl2Icache_tag,
        input  ctrl2Dcache_response, ctrl2Dcache_data, ctrl2Dcache_tag,
        input  d_grant, tag_err
`ifdef MEM_ARBITER_PERF_EN
        , input i_grant_cnt, d_grant_cnt, starve_force_cnt
`endif
    );

endinterface

// File: rtl/mem_tag_table.sv
// Owner table for outstanding memory load tags.
//   clock, reset_n      : clock, async active-low reset (all entries invalid)
//   set_en/tag/who      : record a new owner at the next edge (wins over clear)
//   clr_en/tag          : invalidate an entry at the next edge
//   lk_tag -> lk_entry  : combinational lookup; tag 0 always reads invalid
//   set_hit             : entry addressed by set_tag is currently valid
module mem_tag_table
    import mem_arb_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             set_en,
    input  logic [TAG_W-1:0] set_tag,
    input  owner_e           set_who,
    input  logic             clr_en,
    input  logic [TAG_W-1:0] clr_tag,
    input  logic [TAG_W-1:0] lk_tag,
    output tag_entry_t       lk_entry,
    output logic             set_hit
);

    tag_entry_t entries [NUM_TAGS];

    // Table update: a set to the same tag as a clear takes precedence.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_TAGS; i++) begin
                entries[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_TAGS; i++) begin
                if (set_en && set_tag == TAG_W'(i)) begin
                    entries[i] <= tag_entry_t'{valid: 1'b1, who: set_who};
                end else if (clr_en && clr_tag == TAG_W'(i)) begin
                    entries[i] <= '0;
                end
            end
        end
    end

    // Tag 0 means "no tag", so it never reports an owner.
    always_comb begin
        lk_entry = '0;
        if (lk_tag != '0) begin
            lk_entry = entries[lk_tag];
        end
    end

    assign set_hit = entries[set_tag].valid;

endmodule

// File: rtl/mem_arbiter.sv
// Memory-port arbiter between Icache and Dcache.
// Dcache wins by default; after STARVE_LIMIT consecutive waiting cycles the
// Icache is forced through. Accepted load tags are recorded with their owner
// so returned data can be steered back to the right cache.
//   clock, reset_n : clock, async active-low reset (outputs quiet while low)
//   bus (slave)    : cache requests, memory responses, forwarded command,
//                    per-cache responses/returns, d_grant, sticky tag_err
// Build option MEM_ARBITER_PERF_EN: adds 32-bit i_grant_cnt, d_grant_cnt and
// starve_force_cnt counters to the bus.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic         clock,
    input  logic         reset_n,
    mem_arbiter_if.slave bus
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    logic          i_req;
    logic          d_req;
    logic          i_win;
    logic          d_win;
    logic [SW-1:0] starve_cnt;
    logic [SW-1:0] starve_cnt_nxt;
    logic          tag_err_q;
    logic          tag_err_nxt;

    logic          set_en;
    owner_e        set_who;
    logic          set_hit;
    logic          ret_on;
    logic          ret_hit;
    logic          ret_miss;
    logic          fault;
    tag_entry_t    lk_entry;

    assign i_req = (bus.Icache2ctrl_command != BUS_NONE);
    assign d_req = (bus.Dcache2ctrl_command != BUS_NONE);

    // Grant selection; gating on reset_n keeps every output quiet in reset.
    always_comb begin
        d_win = 1'b0;
        i_win = 1'b0;
        if (reset_n) begin
            if (d_req && (starve_cnt < SW'(STARVE_LIMIT))) begin
                d_win = 1'b1;
            end else if (i_req) begin
                i_win = 1'b1;
            end
        end
    end

    // Starvation counter: counts waiting Icache cycles, saturating at the limit.
    always_comb begin
        starve_cnt_nxt = '0;
        if (i_req && !i_win) begin
            starve_cnt_nxt = (starve_cnt == SW'(STARVE_LIMIT)) ? starve_cnt
                                                               : starve_cnt + SW'(1);
        end
    end

    // Forward the granted request to memory and route its accept tag back.
    always_comb begin
        bus.proc2mem_command     = BUS_NONE;
        bus.proc2mem_addr        = '0;
        bus.proc2mem_data        = '0;
        bus.ctrl2Icache_response = '0;
        bus.ctrl2Dcache_response = '0;
        bus.d_grant              = d_win;
        if (d_win) begin
            bus.proc2mem_command     = bus.Dcache2ctrl_command;
            bus.proc2mem_addr        = bus.Dcache2ctrl_addr;
            bus.proc2mem_data        = bus.Dcache2ctrl_data;
            bus.ctrl2Dcache_response = bus.mem2proc_response;
        end else if (i_win) begin
            bus.proc2mem_command     = bus.Icache2ctrl_command;
            bus.proc2mem_addr        = bus.Icache2ctrl_addr;
            bus.ctrl2Icache_response = bus.mem2proc_response;
        end
    end

    // Only accepted loads expect a data return, so only they claim a tag.
    assign set_who = d_win ? OWN_D : OWN_I;
    assign set_en  = (d_win || i_win) && (bus.proc2mem_command == BUS_LOAD)
                     && (bus.mem2proc_response != '0);

    assign ret_on   = reset_n && (bus.mem2proc_tag != '0);
    assign ret_hit  = ret_on && lk_entry.valid;
    assign ret_miss = ret_on && !lk_entry.valid;

    // Re-accepting a live tag is a fault unless that tag is retiring this cycle.
    assign fault = set_en && set_hit
                   && !(ret_hit && (bus.mem2proc_tag == bus.mem2proc_response));

    assign tag_err_nxt = tag_err_q | ret_miss | fault;

    mem_tag_table u_tag_table (
        .clock    (clock),
        .reset_n  (reset_n),
        .set_en   (set_en),
        .set_tag  (bus.mem2proc_response),
        .set_who  (set_who),
        .clr_en   (ret_hit),
        .clr_tag  (bus.mem2proc_tag),
        .lk_tag   (bus.mem2proc_tag),
        .lk_entry (lk_entry),
        .set_hit  (set_hit)
    );

    // Steer returned data to the recorded owner; unowned returns are dropped.
    always_comb begin
        bus.ctrl2Icache_data = '0;
        bus.ctrl2Icache_tag  = '0;
        bus.ctrl2Dcache_data = '0;
        bus.ctrl2Dcache_tag  = '0;
        if (ret_hit) begin
            if (lk_entry.who == OWN_I) begin
                bus.ctrl2Icache_data = bus.mem2proc_data;
                bus.ctrl2Icache_tag  = bus.mem2proc_tag;
            end else begin
                bus.ctrl2Dcache_data = bus.mem2proc_data;
                bus.ctrl2Dcache_tag  = bus.mem2proc_tag;
            end
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
            tag_err_q  <= 1'b0;
        end else begin
            starve_cnt <= starve_cnt_nxt;
            tag_err_q  <= tag_err_nxt;
        end
    end

    assign bus.tag_err = tag_err_q;

`ifdef MEM_ARBITER_PERF_EN
    logic [31:0] i_grant_q;
    logic [31:0] d_grant_q;
    logic [31:0] force_q;

    // Performance counters; a forced cycle is an Icache grant over a live D request.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            i_grant_q <= '0;
            d_grant_q <= '0;
            force_q   <= '0;
        end else begin
            if (i_win) begin
                i_grant_q <= i_grant_q + 32'd1;
            end
            if (d_win) begin
                d_grant_q <= d_grant_q + 32'd1;
            end
            if (i_win && d_req) begin
                force_q <= force_q + 32'd1;
            end
        end
    end

    assign bus.i_grant_cnt      = i_grant_q;
    assign bus.d_grant_cnt      = d_grant_q;
    assign bus.starve_force_cnt = force_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a vector table for single-cycle
// behaviour plus hand sequences for starvation, tag reuse and reset.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    typedef struct {
        logic [1:0]  icmd;
        logic [31:0] iaddr;
        logic [1:0]  dcmd;
        logic [31:0] daddr;
        logic [63:0] ddata;
        logic [3:0]  resp;
        logic [63:0] mdata;
        logic [3:0]  mtag;
    } in_t;

    typedef struct {
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [63:0] pdata;
        logic [3:0]  iresp;
        logic [3:0]  dresp;
        logic [63:0] idata;
        logic [3:0]  itag;
        logic [63:0] ddat;
        logic [3:0]  dtag;
        logic        dg;
        logic        terr;
    } out_t;

    typedef struct {
        in_t  in;
        out_t exp;
    } vec_t;

    logic clock;
    logic reset_n;
    int   n_checks;
    int   n_errors;
    out_t sb[$];
    int   exp_i_grants;
    int   exp_d_grants;
    int   exp_forced;

    mem_arbiter_if bus ();

    mem_arbiter #(.STARVE_LIMIT(8)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    function automatic in_t mk_in(logic [1:0] icmd, logic [31:0] iaddr, logic [1:0] dcmd,
                                  logic [31:0] daddr, logic [63:0] ddata, logic [3:0] resp,
                                  logic [63:0] mdata, logic [3:0] mtag);
        in_t v;
        v.icmd = icmd; v.iaddr = iaddr; v.dcmd = dcmd; v.daddr = daddr;
        v.ddata = ddata; v.resp = resp; v.mdata = mdata; v.mtag = mtag;
        return v;
    endfunction

    function automatic out_t mk_out(logic [1:0] cmd, logic [31:0] addr, logic [63:0] pdata,
                                    logic [3:0] iresp, logic [3:0] dresp, logic [63:0] idata,
                                    logic [3:0] itag, logic [63:0] ddat, logic [3:0] dtag,
                                    logic dg, logic terr);
        out_t o;
        o.cmd = cmd; o.addr = addr; o.pdata = pdata; o.iresp = iresp; o.dresp = dresp;
        o.idata = idata; o.itag = itag; o.ddat = ddat; o.dtag = dtag; o.dg = dg; o.terr = terr;
        return o;
    endfunction

    function automatic in_t idle_in();
        return mk_in(BUS_NONE, 32'h0, BUS_NONE, 32'h0, 64'h0, 4'd0, 64'h0, 4'd0);
    endfunction

    function automatic out_t quiet_out(logic terr);
        return mk_out(BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd0, 64'h0, 4'd0, 64'h0, 4'd0, 1'b0, terr);
    endfunction

    task automatic chk(input string nm, input string fld, input logic [63:0] act,
                       input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, req);
        end
    endtask

    task automatic drive(input in_t v);
        bus.Icache2ctrl_command = v.icmd;
        bus.Icache2ctrl_addr    = v.iaddr;
        bus.Dcache2ctrl_command = v.dcmd;
        bus.Dcache2ctrl_addr    = v.daddr;
        bus.Dcache2ctrl_data    = v.ddata;
        bus.mem2proc_response   = v.resp;
        bus.mem2proc_data       = v.mdata;
        bus.mem2proc_tag        = v.mtag;
    endtask

    task automatic compare_front(input string nm);
        out_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s.scoreboard: got empty queue expected entry", nm);
            return;
        end
        e = sb.pop_front();
        chk(nm, "cmd",   64'(bus.proc2mem_command),     64'(e.cmd));
        chk(nm, "addr",  64'(bus.proc2mem_addr),        64'(e.addr));
        chk(nm, "pdata", bus.proc2mem_data,             e.pdata);
        chk(nm, "iresp", 64'(bus.ctrl2Icache_response), 64'(e.iresp));
        chk(nm, "dresp", 64'(bus.ctrl2Dcache_response), 64'(e.dresp));
        chk(nm, "idata", bus.ctrl2Icache_data,          e.idata);
        chk(nm, "itag",  64'(bus.ctrl2Icache_tag),      64'(e.itag));
        chk(nm, "ddata", bus.ctrl2Dcache_data,          e.ddat);
        chk(nm, "dtag",  64'(bus.ctrl2Dcache_tag),      64'(e.dtag));
        chk(nm, "dgnt",  64'(bus.d_grant),              64'(e.dg));
        chk(nm, "terr",  64'(bus.tag_err),              64'(e.terr));
    endtask

    // One cycle: drive at negedge, log expectation, sample mid-low-phase.
    task automatic step(input in_t v, input out_t e, input string nm);
        @(negedge clock);
        drive(v);
        sb.push_back(e);
        if (reset_n) begin
            if (e.dg) exp_d_grants++;
            else if (e.cmd != BUS_NONE) begin
                exp_i_grants++;
                if (v.dcmd != BUS_NONE) exp_forced++;
            end
        end
        #2;
        compare_front(nm);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        drive(idle_in());
        @(negedge clock);
        #2;
        reset_n = 1'b1;
        exp_i_grants = 0;
        exp_d_grants = 0;
        exp_forced   = 0;
    endtask

    initial begin
        vec_t vt[14];
        in_t  both;
        out_t e;
        bit   ig;

        n_checks = 0;
        n_errors = 0;
        exp_i_grants = 0;
        exp_d_grants = 0;
        exp_forced   = 0;

        // Quiet outputs while held in reset even with busy inputs.
        reset_n = 1'b0;
        drive(mk_in(BUS_LOAD, 32'h10, BUS_STORE, 32'h20, 64'h5, 4'd3, 64'h9, 4'd3));
        #12;
        sb.push_back(quiet_out(1'b0));
        compare_front("in_reset");
        do_reset();

        vt[0]  = '{idle_in(), quiet_out(1'b0)};
        vt[1]  = '{mk_in(BUS_NONE, 32'h0, BUS_LOAD, 32'h100, 64'h0, 4'd3, 64'h0, 4'd0),
                   mk_out(BUS_LOAD, 32'h100, 64'h0, 4'd0, 4'd3, 64'h0, 4'd0, 64'h0, 4'd0, 1'b1, 1'b0)};
        for (int i = 2; i < 6; i++) vt[i] = '{idle_in(), quiet_out(1'b0)};
        vt[6]  = '{mk_in(BUS_NONE, 32'h0, BUS_NONE, 32'h0, 64'h0, 4'd0, 64'hDEAD, 4'd3),
                   mk_out(BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd0, 64'h0, 4'd0, 64'hDEAD, 4'd3, 1'b0, 1'b0)};
        vt[7]  = '{idle_in(), quiet_out(1'b0)};
        vt[8]  = '{mk_in(BUS_LOAD, 32'h200, BUS_NONE, 32'h0, 64'h0, 4'd5, 64'h0, 4'd0),
                   mk_out(BUS_LOAD, 32'h200, 64'h0, 4'd5, 4'd0, 64'h0, 4'd0, 64'h0, 4'd0, 1'b0, 1'b0)};
        vt[9]  = '{mk_in(BUS_LOAD, 32'h204, BUS_STORE, 32'h300, 64'h1234, 4'd2, 64'h0, 4'd0),
                   mk_out(BUS_STORE, 32'h300, 64'h1234, 4'd0, 4'd2, 64'h0, 4'd0, 64'h0, 4'd0, 1'b1, 1'b0)};
        vt[10] = '{mk_in(BUS_NONE, 32'h0, BUS_NONE, 32'h0, 64'h0, 4'd0, 64'hBEEF, 4'd5),
                   mk_out(BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd0, 64'hBEEF, 4'd5, 64'h0, 4'd0, 1'b0, 1'b0)};
        vt[11] = '{mk_in(BUS_NONE, 32'h0, BUS_LOAD, 32'h400, 64'h0, 4'd0, 64'h0, 4'd0),
                   mk_out(BUS_LOAD, 32'h400, 64'h0, 4'd0, 4'd0, 64'h0, 4'd0, 64'h0, 4'd0, 1'b1, 1'b0)};
        vt[12] = '{mk_in(BUS_NONE, 32'h0, BUS_NONE, 32'h0, 64'h0, 4'd0, 64'h77, 4'd2),
                   quiet_out(1'b0)};
        vt[13] = '{idle_in(), quiet_out(1'b1)};

        for (int i = 0; i < 14; i++) begin
            step(vt[i].in, vt[i].exp, $sformatf("vec%0d", i));
        end

        // Both caches request every cycle: Icache forced on cycles 8 and 17.
        do_reset();
        for (int c = 0; c < 19; c++) begin
            both = mk_in(BUS_LOAD, 32'h10, BUS_LOAD, 32'h20, 64'h0,
                         (c < 12) ? 4'(c + 1) : 4'd0, 64'h0, 4'd0);
            ig = (c == 8) || (c == 17);
            e = mk_out(BUS_LOAD, ig ? 32'h10 : 32'h20, 64'h0,
                       ig ? both.resp : 4'd0, ig ? 4'd0 : both.resp,
                       64'h0, 4'd0, 64'h0, 4'd0, !ig, 1'b0);
            step(both, e, $sformatf("starve%0d", c));
        end
        step(mk_in(BUS_NONE, 32'h0, BUS_NONE, 32'h0, 64'h0, 4'd0, 64'hABC, 4'd9),
             mk_out(BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd0, 64'hABC, 4'd9, 64'h0, 4'd0, 1'b0, 1'b0),
             "ret_i9");
        step(mk_in(BUS_NONE, 32'h0, BUS_NONE, 32'h0, 64'h0, 4'd0, 64'hCD, 4'd1),
             mk_out(BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd0, 64'h0, 4'd0, 64'hCD, 4'd1, 1'b0, 1'b0),
             "ret_d1");
`ifdef MEM_ARBITER_PERF_EN
        chk("perf", "i_grant_cnt", 64'(bus.i_grant_cnt), 64'(exp_i_grants));
        chk("perf", "d_grant_cnt", 64'(bus.d_grant_cnt), 64'(exp_d_grants));
        chk("perf", "starve_force_cnt", 64'(bus.starve_force_cnt), 64'(exp_forced));
        chk("perf", "d_fixed", 64'(bus.d_grant_cnt), 64'd17);
`endif

        // An idle Icache cycle clears the counter: 8 more waits needed afterwards.
        do_reset();
        for (int c = 0; c < 15; c++) begin
            both = mk_in((c == 5) ? BUS_NONE : BUS_LOAD, 32'h10, BUS_LOAD, 32'h20,
                         64'h0, 4'd0, 64'h0, 4'd0);
            ig = (c == 14);
            e = mk_out(BUS_LOAD, ig ? 32'h10 : 32'h20, 64'h0, 4'd0, 4'd0,
                       64'h0, 4'd0, 64'h0, 4'd0, !ig, 1'b0);
            step(both, e, $sformatf("clear%0d", c));
        end

        // Same-cycle return and re-accept of tag 4, then a live-tag re-accept fault.
        do_reset();
        step(mk_in(BUS_NONE, 32'h0, BUS_LOAD, 32'h40, 64'h0, 4'd4, 64'h0, 4'd0),
             mk_out(BUS_LOAD, 32'h40, 64'h0, 4'd0, 4'd4, 64'h0, 4'd0, 64'h0, 4'd0, 1'b1, 1'b0),
             "reuse_d4");
        step(mk_in(BUS_LOAD, 32'h80, BUS_NONE, 32'h0, 64'h0, 4'd4, 64'h55, 4'd4),
             mk_out(BUS_LOAD, 32'h80, 64'h0, 4'd4, 4'd0, 64'h0, 4'd0, 64'h55, 4'd4, 1'b0, 1'b0),
             "reuse_swap");
        step(mk_in(BUS_NONE, 32'h0, BUS_NONE, 32'h0, 64'h0, 4'd0, 64'h66, 4'd4),
             mk_out(BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd0, 64'h66, 4'd4, 64'h0, 4'd0, 1'b0, 1'b0),
             "reuse_i4");
        step(idle_in(), quiet_out(1'b0), "reuse_clean");
        step(mk_in(BUS_NONE, 32'h0, BUS_LOAD, 32'h50, 64'h0, 4'd6, 64'h0, 4'd0),
             mk_out(BUS_LOAD, 32'h50, 64'h0, 4'd0, 4'd6, 64'h0, 4'd0, 64'h0, 4'd0, 1'b1, 1'b0),
             "fault_a");
        step(mk_in(BUS_NONE, 32'h0, BUS_LOAD, 32'h54, 64'h0, 4'd6, 64'h0, 4'd0),
             mk_out(BUS_LOAD, 32'h54, 64'h0, 4'd0, 4'd6, 64'h0, 4'd0, 64'h0, 4'd0, 1'b1, 1'b0),
             "fault_b");
        step(mk_in(BUS_NONE, 32'h0, BUS_NONE, 32'h0, 64'h0, 4'd0, 64'h11, 4'd6),
             mk_out(BUS_NONE, 32'h0, 64'h0, 4'd0, 4'd0, 64'h0, 4'd0, 64'h11, 4'd6, 1'b0, 1'b1),
             "fault_ret");

        // Reset mid-flight: pre-reset tag 7 returns unowned afterwards.
        do_reset();
        step(mk_in(BUS_LOAD, 32'h90, BUS_NONE, 32'h0, 64'h0, 4'd7, 64'h0, 4'd0),
             mk_out(BUS_LOAD, 32'h90, 64'h0, 4'd7, 4'd0, 64'h0, 4'd0, 64'h0, 4'd0, 1'b0, 1'b0),
             "rst_accept");
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            reset_n = 1'b0;
            drive(mk_in(BUS_LOAD, 32'h94, BUS_STORE, 32'h98, 64'h3, 4'd3, 64'h99, 4'd7));
            sb.push_back(quiet_out(1'b0));
            #2;
            compare_front($sformatf("rst_low%0d", c));
        end
        drive(idle_in());
        reset_n = 1'b1;
        step(mk_in(BUS_NONE, 32'h0, BUS_NONE, 32'h0, 64'h0, 4'd0, 64'h99, 4'd7),
             quiet_out(1'b0), "rst_drop");
        step(idle_in(), quiet_out(1'b1), "rst_err");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
